// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and widths used by the memory-access stage.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem.sv
// Data memory: combinational read port, synchronous write port, no reset.
module data_mem
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: fixed-latency data-memory access with an upstream stall and
// a bubble into MEM/WB until the access completes.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [REG_W-1:0]  mdestReg,
    input  logic [DATA_W-1:0] mr,
    input  logic [DATA_W-1:0] mqb,
    output logic              stall,
    output logic              owreg,
    output logic              om2reg,
    output logic [REG_W-1:0]  odestReg,
    output logic [DATA_W-1:0] or_,
    output logic [DATA_W-1:0] odo
);

    // Counter preload: BUSY lasts MEM_LAT-1 cycles, the IDLE cycle is the first stall
    localparam logic [3:0] LAT_M2 = (MEM_LAT >= 2) ? 4'(MEM_LAT - 2) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_rdata;

    state_t            w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_enter_done;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_index;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_req   = mm2reg | mwmem;
    assign w_index = mr[ADDR_W+1:2];

    data_mem #(
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (w_index),
        .i_wdata (mqb),
        .i_raddr (w_index),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_enter_done) begin
                r_rdata <= w_mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_done = 1'b0;
        w_we         = 1'b0;
        stall        = 1'b0;
        owreg        = 1'b0;
        om2reg       = 1'b0;
        odestReg     = '0;
        or_          = '0;
        odo          = '0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    stall = 1'b1;
                    if (MEM_LAT == 1) begin
                        w_state_nxt  = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = LAT_M2;
                    end
                end else begin
                    owreg    = mwreg;
                    om2reg   = mm2reg;
                    odestReg = mdestReg;
                    or_      = mr;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                // Upstream was held, so the inputs still belong to this access
                owreg       = mwreg;
                om2reg      = mm2reg;
                odestReg    = mdestReg;
                or_         = mr;
                odo         = mm2reg ? r_rdata : '0;
                w_we        = mwmem;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Reset silences every output and blocks a pending store commit
        if (!resetn) begin
            w_we     = 1'b0;
            stall    = 1'b0;
            owreg    = 1'b0;
            om2reg   = 1'b0;
            odestReg = '0;
            or_      = '0;
            odo      = '0;
        end
    end

endmodule
